vga_sync_rx: RTL and testbench
==============================

// Module: vga_sync_rx
// PURPOSE
//  Receive end of the 640x480@60 VGA timing: samples active-low HS/VS at the 25 MHz pixel clock
//  and rebuilds x/y/blank so a downstream block can process a captured or looped-back display stream.
//  Locks to the incoming sync phase, flags loss of sync, optionally measures line/frame periods.
// PARAMETERS
//  H_ACTIVE      640  visible pixels per line
//  H_TOTAL       800  pixel clocks per line
//  H_SYNC_START  656  x value of first HS-low pixel
//  V_ACTIVE      480  visible lines per frame
//  V_TOTAL       525  lines per frame
//  V_SYNC_START  490  y value of first VS-low line (VS falls at x=0)
//  LOCK_LINES    4    consecutive in-phase HS edges needed for horizontal lock (>=1)
// PORTS
//  clk          in   1   pixel clock, 25 MHz
//  reset        in   1   synchronous, active-high
//  HS           in   1   horizontal sync, active low
//  VS           in   1   vertical sync, active low
//  x            out  10  recovered pixel column
//  y            out  10  recovered line
//  blank        out  1   1 = outside active area or not locked
//  locked       out  1   1 = state LOCKED
//  frame_start  out  1   1-cycle pulse, x==0 && y==0 while locked
//  sync_err     out  1   1-cycle pulse on loss of lock
//  h_meas       out  10  measured clocks between HS falls (macro only)
//  v_meas       out  10  measured lines between VS falls (macro only)
// BEHAVIOUR
//  - Input: hs_d1<=HS, hs_d2<=hs_d1 (same for VS); hs_fall = hs_d2 & ~hs_d1. Sync flops reset to 1 (no false edge).
//  - Latency 2: when locked, x/y at cycle n equal transmitter counters at cycle n-2.
//  - Counters free-run: x==H_TOTAL-1 -> x=0, y+=1; at y==V_TOTAL-1 also y=0.
//  - hs_fall: x<=H_SYNC_START; in-phase iff pre-load x==H_SYNC_START-1.
//  - vs_fall: y<=V_SYNC_START (overrides increment/wrap); in-phase iff pre-load y==V_SYNC_START-1 and x==H_TOTAL-1.
//  - Same-cycle hs_fall+vs_fall: both loads apply; each judged independently.
//  - FSM: SEARCH -> (LOCK_LINES consecutive in-phase hs_fall; out-of-phase restarts count at 0; first edge
//    counts as in-phase) -> VWAIT -> (any vs_fall, aligns y) -> VCHECK -> (in-phase vs_fall) -> LOCKED.
//    VCHECK: out-of-phase vs_fall stays in VCHECK (re-aligned). Out-of-phase hs_fall in VWAIT/VCHECK -> SEARCH.
//  - LOCKED: out-of-phase hs_fall or vs_fall -> SEARCH, sync_err=1 for one cycle.
//  - Watchdog: 2*H_TOTAL clocks without hs_fall, any state but SEARCH -> SEARCH; sync_err pulses if was LOCKED.
//  - blank = ~locked | x>=H_ACTIVE | y>=V_ACTIVE (combinational from regs).
//  - Reset (incl. mid-frame): x=0, y=0, state SEARCH, locked=0, blank=1, frame_start=0, sync_err=0, h_meas=v_meas=0.
// CONFIGURATION
//  VGA_RX_MEASURE_EN defined: 10-bit period counters; on each hs_fall h_meas<=clocks since previous hs_fall
//    (saturate 1023), on each vs_fall v_meas<=hs_falls since previous vs_fall (saturate 1023);
//    first edge after reset does not update.
//  Not defined: h_meas/v_meas tied 0, counters not built; ports still present.
// TESTING
//  1 Reset, then drive from 640x480 generator -> locked rises after 4 lines + 2 VS falls; x/y == gen x/y delayed 2 clk.
//  2 Locked, check flags -> blank=0 at x=0..639,y=0..479, blank=1 at x=640 or y=480; frame_start once per 420000 clk.
//  3 Locked, HS phase shifted +3 clk on one line -> sync_err 1 clk, locked=0, re-lock next frame.
//  4 Locked, HS held high 1600 clk -> watchdog: locked=0, sync_err pulse, blank=1.
//  5 Reset asserted mid-frame (y=200) for 1 clk -> x=0,y=0,locked=0 next cycle; no false hs_fall after release.
//  6 VGA_RX_MEASURE_EN, nominal stream 2 frames -> h_meas=800, v_meas=525; undefined build -> both read 0.

Source files
------------

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: receive-side 640x480@60 timing recovery.
// Samples active-low HS/VS at the pixel clock and rebuilds x/y/blank, locked to
// the incoming sync phase. Recovered x/y lag the transmitter counters by 2 clocks.
// Optional build macro: VGA_RX_MEASURE_EN enables the line/frame period counters
// behind h_meas/v_meas. When it is undefined those ports read 0.
module vga_sync_rx #(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int LOCK_LINES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       HS,
  input  logic       VS,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       blank,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err,
  output logic [9:0] h_meas,
  output logic [9:0] v_meas
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_LOAD = 10'(H_SYNC_START);
  localparam logic [9:0] V_LOAD = 10'(V_SYNC_START);
  localparam logic [9:0] H_PRE  = 10'(H_SYNC_START - 1);
  localparam logic [9:0] V_PRE  = 10'(V_SYNC_START - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam int CW  = $clog2(LOCK_LINES + 1);
  localparam int WDW = $clog2(2 * H_TOTAL + 1);
  localparam logic [CW-1:0]  LOCK_LAST = CW'(LOCK_LINES - 1);
  localparam logic [WDW-1:0] WD_LIMIT  = WDW'(2 * H_TOTAL - 1);

  typedef enum logic [1:0] {SEARCH, VWAIT, VCHECK, LOCKED} state_t;

  logic           hs_d1_reg, hs_d2_reg, vs_d1_reg, vs_d2_reg;
  logic           hs_fall, vs_fall;
  logic           hs_in_phase, vs_in_phase, wd_expired;
  logic [9:0]     x_reg, y_reg;
  logic [WDW-1:0] wd_reg;
  logic [CW-1:0]  lock_cnt_reg;
  logic           first_reg;
  logic           locked_reg, sync_err_reg;
  state_t         state_reg;

  // Two-stage input sampling; idle-high reset value avoids a fall on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_d1_reg <= 1'b1;
      hs_d2_reg <= 1'b1;
      vs_d1_reg <= 1'b1;
      vs_d2_reg <= 1'b1;
    end else begin
      hs_d1_reg <= HS;
      hs_d2_reg <= hs_d1_reg;
      vs_d1_reg <= VS;
      vs_d2_reg <= vs_d1_reg;
    end
  end

  assign hs_fall     = hs_d2_reg & ~hs_d1_reg;
  assign vs_fall     = vs_d2_reg & ~vs_d1_reg;
  // Edges are judged against the counter value they are about to overwrite.
  assign hs_in_phase = (x_reg == H_PRE);
  assign vs_in_phase = (y_reg == V_PRE) && (x_reg == H_LAST);
  assign wd_expired  = (wd_reg == WD_LIMIT) && !hs_fall;

  // Free-running pixel/line counters, re-phased by every sync fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      if (hs_fall)
        x_reg <= H_LOAD;
      else if (x_reg == H_LAST)
        x_reg <= '0;
      else
        x_reg <= x_reg + 10'd1;

      if (vs_fall)
        y_reg <= V_LOAD;
      else if (x_reg == H_LAST)
        y_reg <= (y_reg == V_LAST) ? 10'd0 : y_reg + 10'd1;
    end
  end

  // Watchdog: clocks since the last HS fall, saturating at the timeout point.
  always_ff @(posedge clk) begin
    if (reset)
      wd_reg <= '0;
    else if (hs_fall)
      wd_reg <= '0;
    else if (wd_reg != WD_LIMIT)
      wd_reg <= wd_reg + 1'b1;
  end

  // Lock state machine with registered locked/sync_err flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= SEARCH;
      lock_cnt_reg <= '0;
      first_reg    <= 1'b1;
      locked_reg   <= 1'b0;
      sync_err_reg <= 1'b0;
    end else begin
      sync_err_reg <= 1'b0;
      case (state_reg)
        SEARCH: begin
          if (hs_fall) begin
            first_reg <= 1'b0;
            // The very first edge has nothing to be compared with.
            if (first_reg || hs_in_phase) begin
              if (lock_cnt_reg == LOCK_LAST) begin
                lock_cnt_reg <= '0;
                state_reg    <= VWAIT;
              end else begin
                lock_cnt_reg <= lock_cnt_reg + 1'b1;
              end
            end else begin
              lock_cnt_reg <= '0;
            end
          end
        end
        VWAIT: begin
          if (wd_expired || (hs_fall && !hs_in_phase))
            state_reg <= SEARCH;
          else if (vs_fall)
            state_reg <= VCHECK;
        end
        VCHECK: begin
          if (wd_expired || (hs_fall && !hs_in_phase)) begin
            state_reg <= SEARCH;
          end else if (vs_fall && vs_in_phase) begin
            state_reg  <= LOCKED;
            locked_reg <= 1'b1;
          end
        end
        LOCKED: begin
          if (wd_expired || (hs_fall && !hs_in_phase) || (vs_fall && !vs_in_phase)) begin
            state_reg    <= SEARCH;
            locked_reg   <= 1'b0;
            sync_err_reg <= 1'b1;
          end
        end
        default: begin
          state_reg  <= SEARCH;
          locked_reg <= 1'b0;
        end
      endcase
    end
  end

  assign x           = x_reg;
  assign y           = y_reg;
  assign locked      = locked_reg;
  assign sync_err    = sync_err_reg;
  assign blank       = ~locked_reg | (x_reg >= H_ACT) | (y_reg >= V_ACT);
  assign frame_start = locked_reg & (x_reg == 10'd0) & (y_reg == 10'd0);

`ifdef VGA_RX_MEASURE_EN
  logic [9:0] h_cnt_reg, v_cnt_reg, h_meas_reg, v_meas_reg;
  logic [9:0] v_cnt_inc;
  logic       h_seen_reg, v_seen_reg;

  // HS falls seen so far in this frame, including one arriving this cycle.
  assign v_cnt_inc = (hs_fall && v_cnt_reg != 10'd1023) ? v_cnt_reg + 10'd1 : v_cnt_reg;

  // Period counters; the first edge after reset only starts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_reg  <= '0;
      v_cnt_reg  <= '0;
      h_meas_reg <= '0;
      v_meas_reg <= '0;
      h_seen_reg <= 1'b0;
      v_seen_reg <= 1'b0;
    end else begin
      if (hs_fall) begin
        h_cnt_reg  <= 10'd1;
        h_seen_reg <= 1'b1;
        if (h_seen_reg)
          h_meas_reg <= h_cnt_reg;
      end else if (h_cnt_reg != 10'd1023) begin
        h_cnt_reg <= h_cnt_reg + 10'd1;
      end

      if (vs_fall) begin
        v_cnt_reg  <= '0;
        v_seen_reg <= 1'b1;
        if (v_seen_reg)
          v_meas_reg <= v_cnt_inc;
      end else begin
        v_cnt_reg <= v_cnt_inc;
      end
    end
  end

  assign h_meas = h_meas_reg;
  assign v_meas = v_meas_reg;
`else
  assign h_meas = '0;
  assign v_meas = '0;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: drives vga_sync_rx from a scaled-down timing generator
// (24x12 total, 16x8 active) and checks lock, flags, fault recovery and reset.
module tb_vga_sync_rx;
  localparam int HA = 16, HT = 24, HSS = 18, HSW = 2;
  localparam int VA = 8,  VT = 12, VSS = 9,  VSW = 2;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset;
  logic       HS, VS;
  logic [9:0] x, y, h_meas, v_meas;
  logic       blank, locked, frame_start, sync_err;

  vga_sync_rx #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .LOCK_LINES(4)
  ) dut (
    .clk(clk), .reset(reset), .HS(HS), .VS(VS), .x(x), .y(y),
    .blank(blank), .locked(locked), .frame_start(frame_start),
    .sync_err(sync_err), .h_meas(h_meas), .v_meas(v_meas)
  );

  always #5 clk = ~clk;

  // Reference transmitter
  int   gen_x = 0, gen_y = 0;
  int   gx_d1 = 0, gx_d2 = 0, gy_d1 = 0, gy_d2 = 0;
  logic gen_en = 1'b0, hs_hold = 1'b0, hs_shift = 1'b0;
  int   hs_start;

  always @(posedge clk) begin
    if (gen_en) begin
      gen_x <= (gen_x == HT - 1) ? 0 : gen_x + 1;
      if (gen_x == HT - 1) gen_y <= (gen_y == VT - 1) ? 0 : gen_y + 1;
    end
    gx_d1 <= gen_x; gx_d2 <= gx_d1;
    gy_d1 <= gen_y; gy_d2 <= gy_d1;
  end

  assign hs_start = HSS + (hs_shift ? 3 : 0);
  assign HS = ~(gen_en && !hs_hold && gen_x >= hs_start && gen_x < hs_start + HSW);
  assign VS = ~(gen_en && gen_y >= VSS && gen_y < VSS + VSW);

  int checks = 0, errors = 0;
  int serr_cnt = 0, fs_cnt = 0, trk_fail = 0;
  logic track_en = 1'b0;

  // Continuous 2-clock-latency tracking check while locked
  always @(negedge clk) begin
    if (sync_err) serr_cnt++;
    if (frame_start) fs_cnt++;
    if (track_en && locked) begin
      checks++;
      if (int'(x) != gx_d2 || int'(y) != gy_d2) begin
        errors++;
        if (trk_fail < 8)
          $display("FAIL track: got x=%0d y=%0d expected x=%0d y=%0d", x, y, gx_d2, gy_d2);
        trk_fail++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_locked(input int bound, output int n);
    n = 0;
    while (!locked && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_gen(input int wx, input int wy, input string name);
    int n = 0;
    while (!(gen_x == wx && gen_y == wy) && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * FRAME) chk({name, "_timeout"}, n, -1);
  endtask

  typedef struct {
    int wx;
    int wy;
    int eb;
    int efs;
  } vec_t;
  vec_t vecs[11];

  initial begin
    int n;
    vecs[0]  = '{0, 0, 0, 1};
    vecs[1]  = '{15, 0, 0, 0};
    vecs[2]  = '{16, 0, 1, 0};
    vecs[3]  = '{23, 0, 1, 0};
    vecs[4]  = '{0, 7, 0, 0};
    vecs[5]  = '{15, 7, 0, 0};
    vecs[6]  = '{16, 7, 1, 0};
    vecs[7]  = '{0, 8, 1, 0};
    vecs[8]  = '{5, 11, 1, 0};
    vecs[9]  = '{23, 11, 1, 0};
    vecs[10] = '{3, 4, 0, 0};

    // Reset state
    reset = 1'b1;
    cyc(3);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_blank", int'(blank), 1);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_serr", int'(sync_err), 0);
    chk("rst_hmeas", int'(h_meas), 0);
    chk("rst_vmeas", int'(v_meas), 0);

    // Acquisition: 4 HS falls, VS fall at gen cycle 216, in-phase VS fall at 504
    reset  = 1'b0;
    gen_en = 1'b1;
    wait_locked(3 * FRAME, n);
    chk("lock_cycle", n, 506);
    chk("lock_x", int'(x), gx_d2);
    chk("lock_y", int'(y), gy_d2);
    track_en = 1'b1;

    // Flag table, indexed by recovered position
    foreach (vecs[i]) begin
      n = 0;
      while (!(int'(x) == vecs[i].wx && int'(y) == vecs[i].wy) && n < 2 * FRAME) begin
        @(negedge clk);
        n++;
      end
      if (n >= 2 * FRAME) chk($sformatf("pos_timeout[%0d]", i), n, -1);
      chk($sformatf("blank[%0d]", i), int'(blank), vecs[i].eb);
      chk($sformatf("fs[%0d]", i), int'(frame_start), vecs[i].efs);
    end
    fs_cnt = 0;
    cyc(2 * FRAME);
    chk("fs_per_2frames", fs_cnt, 2);
    chk("serr_nominal", serr_cnt, 0);

    // HS shifted +3 clocks on a single line
    wait_gen(0, 2, "shift_start");
    track_en = 1'b0;
    serr_cnt = 0;
    hs_shift = 1'b1;
    cyc(HT);
    hs_shift = 1'b0;
    cyc(HT);
    chk("shift_serr", serr_cnt, 1);
    chk("shift_locked", int'(locked), 0);
    chk("shift_blank", int'(blank), 1);
    wait_locked(3 * FRAME, n);
    chk("shift_relock", int'(locked), 1);
    track_en = 1'b1;

    // HS held high: watchdog fires 2*HT clocks after the last fall
    wait_gen(0, 3, "wd_start");
    track_en = 1'b0;
    serr_cnt = 0;
    hs_hold  = 1'b1;
    cyc(40);
    chk("wd_early_locked", int'(locked), 1);
    cyc(8);
    chk("wd_locked", int'(locked), 0);
    chk("wd_serr", serr_cnt, 1);
    chk("wd_blank", int'(blank), 1);
    hs_hold = 1'b0;
    wait_locked(3 * FRAME, n);
    chk("wd_relock", int'(locked), 1);
    track_en = 1'b1;

    // One-clock reset mid-frame while HS is idle high
    n = 0;
    while (!(int'(x) == 2 && int'(y) == 5) && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * FRAME) chk("midrst_timeout", n, -1);
    track_en = 1'b0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("midrst_x", int'(x), 0);
    chk("midrst_y", int'(y), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_blank", int'(blank), 1);
    cyc(5);
    chk("midrst_no_false_edge", int'(x), 5);

    // Period measurement after re-lock
    wait_locked(3 * FRAME, n);
    chk("midrst_relock", int'(locked), 1);
    track_en = 1'b1;
    cyc(FRAME);
`ifdef VGA_RX_MEASURE_EN
    chk("h_meas", int'(h_meas), HT);
    chk("v_meas", int'(v_meas), VT);
`else
    chk("h_meas", int'(h_meas), 0);
    chk("v_meas", int'(v_meas), 0);
`endif

    track_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
